// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus of the MIPS32 front end: instruction-memory port, redirect/halt
// controls from the core, and the valid/ready instruction stream to decode.
interface instr_fetch_ctrl_if;
  logic [31:0] Address;
  logic [31:0] Instruction;
  logic        Redirect;
  logic [31:0] RedirectPC;
  logic        Halt;
  logic        InstrValid;
  logic [31:0] InstrOut;
  logic [31:0] InstrPC;
  logic        InstrReady;
  logic [31:0] FetchCount;

  // The fetch controller is the master: it owns the PC and the instruction stream.
  modport master (
    output Address,
    output InstrValid,
    output InstrOut,
    output InstrPC,
    output FetchCount,
    input  Instruction,
    input  Redirect,
    input  RedirectPC,
    input  Halt,
    input  InstrReady
  );

  modport slave (
    input  Address,
    input  InstrValid,
    input  InstrOut,
    input  InstrPC,
    input  FetchCount,
    output Instruction,
    output Redirect,
    output RedirectPC,
    output Halt,
    output InstrReady
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: owns the PC, fetches from a combinational
// instruction memory and buffers {PC, instruction} pairs in a 2-entry FIFO.
module instr_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                Clk,
  input  logic                Reset_n,
  instr_fetch_ctrl_if.master  fbus
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0] pc_q, pc_d;
  entry_t      head_q, head_d;
  entry_t      tail_q, tail_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  logic        pop;
  logic        push;
  entry_t      new_entry;
  logic [31:0] redirect_target;

  // Handshake decode; pop and push are both resolved from registered state
  // plus the current-cycle control inputs.
  always_comb begin
    pop             = (count_q != 2'd0) && fbus.InstrReady;
    push            = !fbus.Redirect && !fbus.Halt && ((count_q != 2'd2) || pop);
    new_entry       = '{pc: pc_q, instr: fbus.Instruction};
    redirect_target = fbus.RedirectPC & 32'hFFFF_FFFC;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pc_d          = pc_q;
    head_d        = head_q;
    tail_d        = tail_q;
    count_d       = count_q;
    fetch_count_d = fetch_count_q + {31'd0, pop};

    if (fbus.Redirect) begin
      // Flush wins over any push; a pop in the same cycle is still delivered.
      count_d = 2'd0;
      pc_d    = redirect_target;
    end else begin
      if (push) pc_d = pc_q + 32'd4;

      unique case ({push, pop})
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = new_entry;
          end else begin
            head_d = tail_q;
            tail_d = new_entry;
          end
        end
        2'b10: begin
          if (count_q == 2'd0) head_d = new_entry;
          else                 tail_d = new_entry;
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          head_d  = tail_q;
          count_d = count_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pc_q          <= RESET_PC;
      count_q       <= 2'd0;
      fetch_count_q <= 32'd0;
      // NOTE: the buffer slots are reset even though the outputs are already
      // gated by count; it is two entries, and it keeps X out of the datapath.
      head_q        <= '0;
      tail_q        <= '0;
    end else begin
      pc_q          <= pc_d;
      count_q       <= count_d;
      fetch_count_q <= fetch_count_d;
      head_q        <= head_d;
      tail_q        <= tail_d;
    end
  end

  assign fbus.Address    = pc_q;
  assign fbus.InstrValid = (count_q != 2'd0);
  assign fbus.InstrOut   = fbus.InstrValid ? head_q.instr : 32'd0;
  assign fbus.InstrPC    = fbus.InstrValid ? head_q.pc    : 32'd0;
  assign fbus.FetchCount = fetch_count_q;

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Self-checking bench for instr_fetch_ctrl: a queue-based reference of the
// fetch stream feeds a scoreboard checked by an independent monitor.
module tb_instr_fetch_ctrl;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic Clk;
  logic Reset_n;
  instr_fetch_ctrl_if bus();

  instr_fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .fbus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  exp_t        exp_q[$];
  logic [31:0] model_pc  = RESET_PC;
  logic [31:0] model_fc  = 32'd0;
  int          exp_count = 0;
  logic [31:0] exp_addr  = RESET_PC;
  logic [31:0] exp_fc    = 32'd0;
  logic        in_reset  = 1'b1;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h0000_0000: return 32'h2008_0002;
      32'h0000_0004: return 32'h2109_0004;
      default:       return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endcase
  endfunction

  assign bus.Instruction = mem(bus.Address);

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Apply one cycle of stimulus and advance the reference model to the
  // state it will hold after the coming rising edge.
  task automatic apply(input logic rdy, input logic hlt, input logic rdr, input logic [31:0] tgt);
    int   sz;
    logic pop;
    logic push;
    bus.InstrReady = rdy;
    bus.Halt       = hlt;
    bus.Redirect   = rdr;
    bus.RedirectPC = tgt;
    sz        = exp_q.size();
    exp_count = sz;
    exp_addr  = model_pc;
    exp_fc    = model_fc;
    pop  = (sz > 0) && rdy;
    push = !rdr && !hlt && ((sz < 2) || pop);
    if (pop) model_fc = model_fc + 32'd1;
    if (rdr) begin
      while (exp_q.size() > (pop ? 1 : 0)) void'(exp_q.pop_back());
      model_pc = {tgt[31:2], 2'b00};
    end else if (push) begin
      exp_q.push_back('{pc: model_pc, instr: mem(model_pc)});
      model_pc = model_pc + 32'd4;
    end
  endtask

  task automatic step(input logic rdy, input logic hlt, input logic rdr, input logic [31:0] tgt);
    @(negedge Clk);
    apply(rdy, hlt, rdr, tgt);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"},   bus.Address,    RESET_PC);
    check({tag, "_valid"},     {31'd0, bus.InstrValid}, 32'd0);
    check({tag, "_instr"},     bus.InstrOut,   32'd0);
    check({tag, "_pc"},        bus.InstrPC,    32'd0);
    check({tag, "_fetchcnt"},  bus.FetchCount, 32'd0);
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_pc  = RESET_PC;
    model_fc  = 32'd0;
    exp_count = 0;
    exp_addr  = RESET_PC;
    exp_fc    = 32'd0;
  endtask

  // Mid-stream reset with a redirect pending; release applies the given ready.
  task automatic mid_reset(input logic rdy_after);
    @(negedge Clk);
    in_reset       = 1'b1;
    bus.Redirect   = 1'b1;
    bus.RedirectPC = 32'h0000_0100;
    bus.InstrReady = 1'b1;
    bus.Halt       = 1'b0;
    #3 Reset_n = 1'b0;
    #1 check_reset_outputs("midrst_async");
    @(posedge Clk);
    #1 check_reset_outputs("midrst_held");
    reset_model();
    @(negedge Clk);
    Reset_n  = 1'b1;
    in_reset = 1'b0;
    apply(rdy_after, 1'b0, 1'b0, 32'd0);
  endtask

  // Monitor: compares DUT outputs against the scoreboard once per cycle,
  // after stimulus for the cycle has settled and well before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #2;
      if (!in_reset) begin
        check("address",     bus.Address,    exp_addr);
        check("valid",       {31'd0, bus.InstrValid}, {31'd0, exp_count != 0});
        check("fetch_count", bus.FetchCount, exp_fc);
        if (bus.InstrValid && bus.InstrReady) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL spurious_output: got InstrPC=%h with no expected entry", bus.InstrPC);
          end else begin
            e = exp_q.pop_front();
            check("instr_pc",  bus.InstrPC,  e.pc);
            check("instr_out", bus.InstrOut, e.instr);
          end
        end else if (!bus.InstrValid) begin
          check("empty_instr", bus.InstrOut, 32'd0);
          check("empty_pc",    bus.InstrPC,  32'd0);
        end
      end
    end
  end

  initial begin
    Reset_n        = 1'b0;
    bus.Redirect   = 1'b0;
    bus.RedirectPC = 32'd0;
    bus.Halt       = 1'b0;
    bus.InstrReady = 1'b0;
    #2 check_reset_outputs("por");
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset_n  = 1'b1;
    in_reset = 1'b0;
    apply(1'b1, 1'b0, 1'b0, 32'd0);

    // Streaming with ready held high.
    repeat (8) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Reset mid-stream, then backpressure from reset.
    mid_reset(1'b0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'd0);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Fill the buffer, redirect with it full to an unaligned target.
    repeat (3) step(1'b0, 1'b0, 1'b0, 32'd0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0043);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Halt while draining, then resume.
    repeat (3) step(1'b1, 1'b1, 1'b0, 32'd0);
    repeat (4) step(1'b1, 1'b0, 1'b0, 32'd0);

    // PC wrap-around.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (5) step(1'b1, 1'b0, 1'b0, 32'd0);

    // Randomized traffic.
    repeat (3000) step($urandom_range(0, 9) < 7, $urandom_range(0, 7) == 0,
                       $urandom_range(0, 15) == 0, $urandom);

    // Drain with fetch suspended; nothing may remain outstanding.
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'd0);
    #4 check("drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Fetch controller that sequences the combinational instruction memory for the MIPS32 core. Owns the program counter, drives the memory `Address`, captures each returned `Instruction` with its PC into a 2-entry output buffer, and hands instructions to decode over a valid/ready handshake. Sits between instruction memory and the decode stage; accepts branch/jump redirects and a halt request from the core.

## Interface
- `RESET_PC`, default 32'h0000_0000, PC loaded on reset (word aligned).
- `Clk`  in  1  system clock, all state on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Address`  out  32  fetch address to instruction memory; equals PC register.
- `Instruction`  in  32  memory read data, valid in the same cycle as `Address`.
- `Redirect`  in  1  load new PC this cycle (branch/jump taken).
- `RedirectPC`  in  32  redirect target; bits [1:0] ignored (forced 0).
- `Halt`  in  1  suspend fetching while high.
- `InstrValid`  out  1  buffer head holds a valid instruction.
- `InstrOut`  out  32  instruction at buffer head.
- `InstrPC`  out  32  PC of instruction at buffer head.
- `InstrReady`  in  1  decode accepts head when high with `InstrValid`.
- `FetchCount`  out  32  number of instructions delivered (pops) since reset.

## Operation
- State: PC register, 2-entry FIFO of {PC, instruction}, occupancy count (0..2), `FetchCount`.
- Pop: `InstrValid && InstrReady`; removes head, increments `FetchCount` (wraps at 2^32).
- Push condition: `!Redirect && !Halt && (count < 2 || pop)`; pushes {PC, `Instruction`}, PC <= PC + 4.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- Redirect (highest priority): FIFO flushed (count <= 0, pop that cycle still counted in `FetchCount` if it happened), PC <= {RedirectPC[31:2], 2'b00}, no push that cycle.
- Halt without redirect: no push, PC holds; FIFO continues to drain through pops.
- Redirect while halted: PC updated and FIFO flushed; fetch resumes at new PC when `Halt` drops.
- Simultaneous push and pop at count 2: allowed; count stays 2, ordering preserved.
- Simultaneous push and pop at count 1: count stays 1, new entry becomes head next cycle.
- Empty FIFO: `InstrValid`=0, `InstrOut`=0, `InstrPC`=0.
- No instruction is ever duplicated or dropped except by redirect flush.

## Timing
- Reset (asynchronous, `Reset_n`=0): PC=`RESET_PC`, count=0, `FetchCount`=0, `InstrValid`=0, `InstrOut`=0, `InstrPC`=0; `Address`=`RESET_PC` immediately.
- Reset asserted mid-operation clears all state in the same instant regardless of pending pops/redirects.
- `Address` is combinational from PC register only (no path from any input).
- Fetch-to-valid latency: 1 cycle (pushed at edge N, `InstrValid` high in cycle N+1).
- Redirect-to-valid latency: 2 cycles (edge N loads PC, edge N+1 pushes target, valid in N+2).
- Sustained throughput: 1 instruction/cycle with `InstrReady` held high.
- Outputs `InstrValid`, `InstrOut`, `InstrPC`, `FetchCount` are registered/FIFO-head values, no combinational path from `InstrReady`.
- `InstrOut`/`InstrPC` hold stable while `InstrValid && !InstrReady`.

## Test plan
- Reset then stream, `InstrReady`=1, memory holds 32'h2008_0002 @0 and 32'h2109_0004 @4 -> cycle 1 after release: valid, PC 0, instr 32'h2008_0002; next cycle PC 4, instr 32'h2109_0004; `FetchCount` increments each cycle.
- Backpressure: `InstrReady`=0 from reset -> two pushes (PC 0, 4), then `Address` holds 8, head stays PC 0; raise ready -> PCs 0,4,8 delivered in consecutive cycles, none lost.
- Redirect with FIFO full, `RedirectPC`=32'h0000_0043 -> FIFO empties next cycle, `Address`=32'h40, first valid output PC 32'h40 two cycles after redirect.
- Halt for 3 cycles with ready high -> FIFO drains to empty, `Address` constant, `InstrValid`=0; release -> fetch resumes at held PC.
- PC wrap: redirect to 32'hFFFF_FFFC -> delivered PCs FFFF_FFFC then 0000_0000.
- Assert `Reset_n` low mid-stream with redirect pending -> all outputs reset values immediately, `Address`=`RESET_PC`, redirect ignored.
